// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine
//
// Sequential N x N signed matrix multiplier, N = 2**WIDTH_BIT. Operands are
// taken over a valid/ready handshake and C = A*B (or C = A*B + C_prev when
// acc_mode is set) is built with LANES parallel multiply-accumulate units.
// Each CALC cycle handles one (row, column block, k) step.
// One output block of LANES elements is finished every N cycles.
//
// Configuration macro: MATMUL_SAT_EN
//   undefined : DATA_W-bit accumulators, modulo 2**DATA_W arithmetic
//   defined   : wide accumulators (2*DATA_W+WIDTH_BIT+1 bits), result
//               clamped to the signed DATA_W range on write-back
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands present
//   in_ready   out  engine idle and able to accept operands
//   acc_mode   in   sampled on accept; 1 adds the previous result
//   a, b       in   operand matrices, row-major, signed DATA_W elements
//   result     out  registered result matrix
//   out_valid  out  result complete (DONE state)
//   out_ready  in   consumer has taken the result
//   busy       out  computation in progress (CALC state)

module matrix_mac_engine #(
  parameter int WIDTH_BIT = 2,
  parameter int DATA_W = 32,
  parameter int LANES = 2 ** WIDTH_BIT,
  localparam int N = 2 ** WIDTH_BIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 acc_mode,
  input  logic [0:N-1][0:N-1][DATA_W-1:0]      a,
  input  logic [0:N-1][0:N-1][DATA_W-1:0]      b,
  output logic [0:N-1][0:N-1][DATA_W-1:0]      result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  // Counter width; kept at least one bit so N = 1 still elaborates.
  localparam int CW = (WIDTH_BIT > 0) ? WIDTH_BIT : 1;

`ifdef MATMUL_SAT_EN
  localparam int ACC_W = 2 * DATA_W + WIDTH_BIT + 1;
`else
  localparam int ACC_W = DATA_W;
`endif

  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_BLK  = CW'(N - LANES);
  localparam logic [CW-1:0] LANE_STEP = CW'(LANES);

  // A lane count that is not a power of two in [1, N] would leave columns
  // uncovered or overlapping, so it is rejected at elaboration.
  if (LANES < 1 || LANES > N || (LANES & (LANES - 1)) != 0) begin : g_badLanes
    $error("matrix_mac_engine: LANES must be a power of two in [1, N]");
  end

  typedef logic [0:N-1][0:N-1][DATA_W-1:0] matrix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  matrix_t                 aReg_q, aReg_d;
  matrix_t                 bReg_q, bReg_d;
  matrix_t                 result_q, result_d;
  logic                    accMode_q, accMode_d;
  logic [CW-1:0]           rowIdx_q, rowIdx_d;
  logic [CW-1:0]           colBase_q, colBase_d;
  logic [CW-1:0]           kIdx_q, kIdx_d;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];

  logic signed [ACC_W-1:0] laneSum [LANES];
  logic [DATA_W-1:0]       laneOut [LANES];
  logic [CW-1:0]           laneCol [LANES];

`ifdef MATMUL_SAT_EN
  // The value fits DATA_W bits only when every bit from DATA_W-1 upwards
  // equals the sign; otherwise pick the rail matching the sign.
  function automatic logic [DATA_W-1:0] satClamp(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] upper;
    upper = v[ACC_W-1:DATA_W-1];
    if ((&upper) || (~|upper)) begin
      satClamp = v[DATA_W-1:0];
    end else if (v[ACC_W-1]) begin
      satClamp = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      satClamp = {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction
`endif

  // Per-lane MAC datapath. Lane l works on column colBase + l of the
  // current row. At k = 0 the running sum restarts from the old result
  // entry (accumulate) or zero, and that cycle's product is already added.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0] aElem;
    logic signed [DATA_W-1:0] bElem;
    logic signed [DATA_W-1:0] oldElem;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  base;

    assign laneCol[l] = colBase_q + CW'(l);
    assign aElem      = aReg_q[rowIdx_q][kIdx_q];
    assign bElem      = bReg_q[kIdx_q][laneCol[l]];
    assign oldElem    = result_q[rowIdx_q][laneCol[l]];

`ifdef MATMUL_SAT_EN
    logic signed [ACC_W-1:0] aExt;
    logic signed [ACC_W-1:0] bExt;
    logic signed [ACC_W-1:0] oldExt;

    assign aExt   = {{(ACC_W-DATA_W){aElem[DATA_W-1]}}, aElem};
    assign bExt   = {{(ACC_W-DATA_W){bElem[DATA_W-1]}}, bElem};
    assign oldExt = {{(ACC_W-DATA_W){oldElem[DATA_W-1]}}, oldElem};
    assign prod   = aExt * bExt;
    assign base   = (kIdx_q == '0) ? (accMode_q ? oldExt : '0) : acc_q[l];
    assign laneSum[l] = base + prod;
    assign laneOut[l] = satClamp(laneSum[l]);
`else
    assign prod   = aElem * bElem;
    assign base   = (kIdx_q == '0) ? (accMode_q ? oldElem : '0) : acc_q[l];
    assign laneSum[l] = base + prod;
    assign laneOut[l] = laneSum[l];
`endif
  end

  // Next-state logic. Operands are captured on accept so the source may
  // change afterwards. Result entries not in the current block are left
  // untouched, which the accumulate preload depends on.
  always_comb begin
    state_d   = state_q;
    aReg_d    = aReg_q;
    bReg_d    = bReg_q;
    result_d  = result_q;
    accMode_d = accMode_q;
    rowIdx_d  = rowIdx_q;
    colBase_d = colBase_q;
    kIdx_d    = kIdx_q;
    for (int l = 0; l < LANES; l++) begin
      acc_d[l] = acc_q[l];
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = CALC;
          aReg_d    = a;
          bReg_d    = b;
          accMode_d = acc_mode;
          rowIdx_d  = '0;
          colBase_d = '0;
          kIdx_d    = '0;
        end
      end

      CALC: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[l] = laneSum[l];
        end
        if (kIdx_q == LAST_IDX) begin
          // Final k for this block: the sums are complete, so store them.
          for (int l = 0; l < LANES; l++) begin
            result_d[rowIdx_q][laneCol[l]] = laneOut[l];
          end
          kIdx_d = '0;
          if (colBase_q == LAST_BLK) begin
            colBase_d = '0;
            if (rowIdx_q == LAST_IDX) begin
              rowIdx_d = '0;
              state_d  = DONE;
            end else begin
              rowIdx_d = rowIdx_q + 1'b1;
            end
          end else begin
            colBase_d = colBase_q + LANE_STEP;
          end
        end else begin
          kIdx_d = kIdx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aReg_q    <= '0;
      bReg_q    <= '0;
      result_q  <= '0;
      accMode_q <= 1'b0;
      rowIdx_q  <= '0;
      colBase_q <= '0;
      kIdx_q    <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
      end
    end else begin
      state_q   <= state_d;
      aReg_q    <= aReg_d;
      bReg_q    <= bReg_d;
      result_q  <= result_d;
      accMode_q <= accMode_d;
      rowIdx_q  <= rowIdx_d;
      colBase_q <= colBase_d;
      kIdx_q    <= kIdx_d;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign result    = result_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// tb_matrix_mac_engine
//
// Bench for matrix_mac_engine with N = 4. Two engines share the clock,
// reset and operand buses: one with LANES = 4, one with LANES = 1. The
// 'sel' signal routes handshake signals to one engine at a time. Expected
// matrices come from an independent golden model and travel through a
// scoreboard queue from stimulus to result collection.

`timescale 1ns/1ps

module tb_matrix_mac_engine;

  localparam int WB = 2;
  localparam int N  = 4;
  localparam int DW = 32;

  typedef logic [0:N-1][0:N-1][DW-1:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drvValid = 1'b0;
  logic drvReady = 1'b0;
  logic accMode = 1'b0;
  logic sel = 1'b0;
  mat_t opA = '0;
  mat_t opB = '0;

  logic inValid4, inValid1, outReady4, outReady1;
  logic inReady4, outValid4, busy4;
  logic inReady1, outValid1, busy1;
  mat_t result4, result1;

  logic selInReady, selOutValid, selBusy;
  mat_t selResult;

  int checkCount = 0;
  int failCount = 0;
  mat_t expQ[$];
  mat_t modelPrev [2];

  always #5 clk = ~clk;

  assign inValid4  = drvValid & ~sel;
  assign inValid1  = drvValid & sel;
  assign outReady4 = drvReady & ~sel;
  assign outReady1 = drvReady & sel;

  assign selInReady  = sel ? inReady1  : inReady4;
  assign selOutValid = sel ? outValid1 : outValid4;
  assign selBusy     = sel ? busy1     : busy4;
  assign selResult   = sel ? result1   : result4;

  matrix_mac_engine #(.WIDTH_BIT(WB), .DATA_W(DW), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid4), .in_ready(inReady4),
    .acc_mode(accMode), .a(opA), .b(opB), .result(result4),
    .out_valid(outValid4), .out_ready(outReady4), .busy(busy4)
  );

  matrix_mac_engine #(.WIDTH_BIT(WB), .DATA_W(DW), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid1), .in_ready(inReady1),
    .acc_mode(accMode), .a(opA), .b(opB), .result(result1),
    .out_valid(outValid1), .out_ready(outReady1), .busy(busy1)
  );

  // Golden model: full-precision sum, then wrap or clamp to DW bits.
  function automatic mat_t modelMac(input mat_t ma, input mat_t mb, input mat_t prev, input logic accm);
    mat_t r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
`ifdef MATMUL_SAT_EN
        logic signed [127:0] s;
        s = '0;
        if (accm) s = {{96{prev[i][j][DW-1]}}, prev[i][j]};
        for (int k = 0; k < N; k++) begin
          s = s + $signed({{96{ma[i][k][DW-1]}}, ma[i][k]}) * $signed({{96{mb[k][j][DW-1]}}, mb[k][j]});
        end
        if (s > 128'sd2147483647) r[i][j] = 32'h7FFF_FFFF;
        else if (s < -128'sd2147483648) r[i][j] = 32'h8000_0000;
        else r[i][j] = s[DW-1:0];
`else
        logic [DW-1:0] w;
        w = accm ? prev[i][j] : '0;
        for (int k = 0; k < N; k++) begin
          w = w + ma[i][k] * mb[k][j];
        end
        r[i][j] = w;
`endif
      end
    end
    return r;
  endfunction

  function automatic mat_t randMat();
    mat_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        r[i][j] = $urandom;
      end
    end
    return r;
  endfunction

  function automatic int countDiff(input mat_t x, input mat_t y);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (x[i][j] !== y[i][j]) n++;
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetAll();
    @(negedge clk);
    rst = 1'b1;
    drvValid = 1'b0;
    drvReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    modelPrev[0] = '0;
    modelPrev[1] = '0;
  endtask

  // Drive one operation into the selected engine, push its expected result,
  // and measure cycles from accept until out_valid, plus cycles with busy.
  task automatic applyStimulus(input mat_t ma, input mat_t mb, input logic accm, input string tag,
                               input int expLat, input int expBusy);
    mat_t expM;
    int cyc;
    int busyCyc;
    expM = modelMac(ma, mb, modelPrev[sel], accm);
    modelPrev[sel] = expM;
    expQ.push_back(expM);
    @(negedge clk);
    opA = ma;
    opB = mb;
    accMode = accm;
    drvValid = 1'b1;
    checkOutput({tag, "_in_ready"}, 64'(selInReady), 64'd1);
    @(posedge clk);
    #1;
    drvValid = 1'b0;
    opA = randMat();
    opB = randMat();
    accMode = ~accm;
    cyc = 0;
    busyCyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (selBusy) busyCyc++;
      if (selOutValid) break;
    end
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(expLat));
    checkOutput({tag, "_busy_cycles"}, 64'(busyCyc), 64'(expBusy));
  endtask

  task automatic checkResult(input string tag, output mat_t expM);
    expM = '0;
    checkOutput({tag, "_sb_depth"}, 64'(expQ.size()), 64'd1);
    if (expQ.size() != 0) begin
      expM = expQ.pop_front();
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          checkOutput($sformatf("%s_c%0d%0d", tag, i, j), 64'(selResult[i][j]), 64'(expM[i][j]));
        end
      end
    end
  endtask

  task automatic releaseOutput(input string tag);
    @(negedge clk);
    drvReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_rel_in_ready"}, 64'(selInReady), 64'd1);
    checkOutput({tag, "_rel_out_valid"}, 64'(selOutValid), 64'd0);
    drvReady = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mat_t ma;
    mat_t mb;
    mat_t expM;
    mat_t held;

    resetAll();

    // Reset state of both engines.
    checkOutput("rst_in_ready4", 64'(inReady4), 64'd1);
    checkOutput("rst_out_valid4", 64'(outValid4), 64'd0);
    checkOutput("rst_busy4", 64'(busy4), 64'd0);
    checkOutput("rst_result4", 64'(countDiff(result4, '0)), 64'd0);
    checkOutput("rst_in_ready1", 64'(inReady1), 64'd1);
    checkOutput("rst_result1", 64'(countDiff(result1, '0)), 64'd0);

    // Identity: A = I, B[i][j] = 4i+j, result must equal B.
    sel = 1'b0;
    ma = '0;
    for (int i = 0; i < N; i++) begin
      ma[i][i] = 32'd1;
      for (int j = 0; j < N; j++) mb[i][j] = 32'(4 * i + j);
    end
    applyStimulus(ma, mb, 1'b0, "ident", 17, 16);
    checkResult("ident", expM);
    checkOutput("ident_eq_b", 64'(countDiff(result4, mb)), 64'd0);
    releaseOutput("ident");

    // Accumulate: all-2s gives 16, then again with acc_mode gives 32.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 32'd2;
        mb[i][j] = 32'd2;
      end
    end
    applyStimulus(ma, mb, 1'b0, "acc0", 17, 16);
    checkResult("acc0", expM);
    checkOutput("acc0_spot", 64'(result4[3][2]), 64'd16);
    releaseOutput("acc0");
    applyStimulus(ma, mb, 1'b1, "acc1", 17, 16);
    checkResult("acc1", expM);
    checkOutput("acc1_spot", 64'(result4[1][3]), 64'd32);
    releaseOutput("acc1");

    // Overflow: 0x10000 squared wraps to 0 or saturates to the max.
    ma = '0;
    mb = '0;
    ma[0][0] = 32'h0001_0000;
    mb[0][0] = 32'h0001_0000;
    applyStimulus(ma, mb, 1'b0, "ovf", 17, 16);
    checkResult("ovf", expM);
`ifdef MATMUL_SAT_EN
    checkOutput("ovf_spot", 64'(result4[0][0]), 64'h7FFF_FFFF);
`else
    checkOutput("ovf_spot", 64'(result4[0][0]), 64'd0);
`endif
    checkOutput("ovf_zero", 64'(result4[2][2]), 64'd0);
    releaseOutput("ovf");

    // Backpressure: 10 cycles in DONE with a competing in_valid.
    ma = randMat();
    mb = randMat();
    applyStimulus(ma, mb, 1'b0, "bp", 17, 16);
    checkResult("bp", held);
    @(negedge clk);
    opA = randMat();
    opB = randMat();
    accMode = 1'b0;
    drvValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold_valid%0d", c), 64'(outValid4), 64'd1);
      checkOutput($sformatf("bp_hold_ready%0d", c), 64'(inReady4), 64'd0);
      checkOutput($sformatf("bp_hold_stable%0d", c), 64'(countDiff(result4, held)), 64'd0);
    end
    drvValid = 1'b0;
    drvReady = 1'b1;
    @(posedge clk);
    #1;
    drvReady = 1'b0;
    checkOutput("bp_rel_in_ready", 64'(inReady4), 64'd1);
    checkOutput("bp_rel_busy", 64'(busy4), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("bp_idle_busy", 64'(busy4), 64'd0);
    checkOutput("bp_idle_result", 64'(countDiff(result4, held)), 64'd0);

    // Reset on CALC cycle 5, then a fresh accumulate run must start from 0.
    @(negedge clk);
    opA = randMat();
    opB = randMat();
    accMode = 1'b0;
    drvValid = 1'b1;
    @(posedge clk);
    #1;
    drvValid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mrst_busy_before", 64'(busy4), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_in_ready", 64'(inReady4), 64'd1);
    checkOutput("mrst_busy", 64'(busy4), 64'd0);
    checkOutput("mrst_out_valid", 64'(outValid4), 64'd0);
    checkOutput("mrst_result", 64'(countDiff(result4, '0)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelPrev[0] = '0;
    modelPrev[1] = '0;
    ma = randMat();
    mb = randMat();
    applyStimulus(ma, mb, 1'b1, "post", 17, 16);
    checkResult("post", expM);
    releaseOutput("post");

    // Single lane: random signed operands, 64 CALC cycles.
    sel = 1'b1;
    ma = randMat();
    mb = randMat();
    applyStimulus(ma, mb, 1'b0, "lane1", 65, 64);
    checkResult("lane1", expM);
    releaseOutput("lane1");
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
